fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined WISC core. It sits directly upstream of `decode_stage`: owns the fetch PC and drives a variable-latency instruction-memory request/ready interface. It presents one instruction plus its PC+2 per transfer to decode's input register. It absorbs decode stalls with a one-entry skid buffer, squashes wrong-path fetches on branch redirect, and stops fetching after a HLT.

## Interface
- `RESET_PC`, default 16'h0000, fetch address after reset.

- `clk` in 1, core clock.
- `rst` in 1, reset; **synchronous, active-high**.
- `stall` in 1, decode cannot accept this cycle (hazard hold).
- `redirect` in 1, decode resolved a taken branch this cycle (decode's `branch & should_branch`).
- `redirect_pc` in 16, branch target (decode's `next_pc`); bit 0 ignored, treated as 0.
- `imem_req` out 1, fetch request valid.
- `imem_addr` out 16, fetch address; stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready` in 1, `imem_data` is valid for `imem_addr` this cycle; sampled only while `imem_req` is high.
- `imem_data` in 16, instruction word.
- `f_valid` out 1, `f_instruction`/`f_pc_plus2` are valid this cycle.
- `f_instruction` out 16, instruction to decode; 16'h0000 (ADD $0,$0,$0, no-op) when `f_valid` is 0.
- `f_pc_plus2` out 16, fetched address + 2.
- `halted` out 1, fetch stopped on HLT.

## Operation
- Registers: `fetch_pc` (16), `pending_pc` (16), `buf_instr` (16), `buf_pc_plus2` (16), `state`.
- A transfer to decode occurs at an edge where `f_valid & ~stall` holds.
- `f_valid` is forced to 0 whenever `redirect` is high, because anything presented in that cycle is wrong-path.
- State FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - `redirect & imem_ready`: drop the data, `fetch_pc`<=`redirect_pc`, stay in FETCH.
  - `redirect & ~imem_ready`: `pending_pc`<=`redirect_pc`, go to DROP.
  - `imem_ready & ~stall`: `f_valid`=1, `f_instruction`=`imem_data`, `f_pc_plus2`=`fetch_pc`+2. Then `fetch_pc`<=`fetch_pc`+2. Go to HALT if `imem_data[15:12]`==4'hF, else stay in FETCH.
  - `imem_ready & stall`: `f_valid`=1 from `imem_data`, but no transfer happens. Capture into `buf_*`, `fetch_pc`<=`fetch_pc`+2, go to FULL.
  - No `imem_ready`: `f_valid`=0, hold.
- State FULL: `imem_req`=0; outputs are driven from `buf_*`, `f_valid`=1 unless `redirect`.
  - `redirect`: discard the buffer, `fetch_pc`<=`redirect_pc`, go to FETCH. Redirect has priority over `stall`.
  - `~stall`: transfer; go to HALT if `buf_instr[15:12]`==4'hF, else FETCH.
  - `stall`: hold.
- State DROP: `imem_req`=1, `imem_addr`=`fetch_pc` (the old address is held until the memory completes); `f_valid`=0.
  - Another `redirect`: overwrites `pending_pc` (last one wins).
  - `imem_ready`: discard the data, `fetch_pc`<=`pending_pc` (or `redirect_pc` if `redirect` is high in the same cycle), go to FETCH.
- State HALT: `imem_req`=0, `f_valid`=0, `halted`=1.
  - `redirect`: `fetch_pc`<=`redirect_pc`, go to FETCH. This covers a HLT fetched in a branch shadow.
- Arithmetic: `fetch_pc`+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000.

## Timing
- Reset, during an `rst`-high cycle: `imem_req`=0, `f_valid`=0, `halted`=0, `f_instruction`=16'h0000.
- Reset, state after the edge: state=FETCH, `fetch_pc`=`RESET_PC`, `pending_pc`/`buf_*`=0.
- Reset mid-operation abandons any outstanding request or buffered instruction; the memory model is reset alongside.
- First request is issued in the first cycle after `rst` falls.
- `imem_ready` may rise in the first request cycle, giving zero extra latency. The fetched word is presented to decode in that same cycle and latched by decode at the following edge.
- Throughput with `imem_ready` held at 1: one instruction per cycle. An N-cycle memory gives one instruction per N cycles.
- Skid buffer: at most one instruction is held. No request is issued while FULL.
- `halted` rises the cycle after the HLT transfer. It falls the cycle after a redirect.

## Structure
- Shared package/header `wisc_defs`: `OPC_HLT`=4'hF, `NOP_INSTR`=16'h0000, the default `RESET_PC`, and the fetch state encodings (FETCH, FULL, DROP, HALT).
- State and PC registers use the existing `dff` cell.
- The `fetch_pc`+2 incrementer is the one natural sub-module: reuse `cla_16bit` with b=16'h0002, cin=0.

## Test plan
- Reset, `imem_ready`=1 constant, mem[0]=16'h1234, mem[2]=16'h2567: first cycle `imem_addr`=0000, `f_valid`=1, `f_instruction`=1234, `f_pc_plus2`=0002; next cycle `imem_addr`=0002.
- 3-cycle memory latency at address 0002: `imem_addr` held at 0002 for 3 cycles, `f_valid` low for 2 cycles then high.
- `stall` high during a ready cycle at 0004: instruction buffered, `imem_req`=0 while the stall is held. On stall release the buffered word is presented with `f_pc_plus2`=0006, then the request goes to 0006.
- Request at 0010 outstanding, `redirect` to 0040, `imem_ready` arrives 2 cycles later: `imem_addr` stays 0010, `f_valid`=0 throughout, next request is 0040.
- mem[6]=16'hF000: HLT transferred, then `halted`=1 and `imem_req`=0. A later `redirect` to 0020 gives `halted`=0 and a request at 0020.
- `RESET_PC`=16'hFFFE: `f_pc_plus2`=0000 and the next `imem_addr`=0000. Also check that in FULL, `redirect` together with `stall` discards the buffer and the next fetch goes to `redirect_pc`.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the WISC fetch stage: opcodes, reset PC and fetch FSM states.
package fetch_stage_pkg;

    localparam logic [3:0]  OPC_HLT          = 4'hF;
    localparam logic [15:0] NOP_INSTR        = 16'h0000;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam logic [15:0] PC_STEP          = 16'h0002;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and instruction memory.
interface fetch_stage_if;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );

endinterface

// File: rtl/fetch_stage_cells.sv
// Library cells reused by the fetch stage: resettable register and 16-bit carry-lookahead adder.
module dff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    // Four 4-bit lookahead groups; each group's carry-out feeds the next group directly.
    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int unsigned B = 4 * k;

        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);

        if (k < 3) begin : g_next
            assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B])
                          | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the fetch PC, drives imem, skid-buffers one
// instruction across decode stalls, squashes wrong-path fetches and stops on HLT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic                 f_valid,
    output logic [15:0]          f_instruction,
    output logic [15:0]          f_pc_plus2,
    output logic                 halted
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [1:0]   state_bits;

    logic [15:0] fetch_pc,     fetch_pc_d;
    logic [15:0] pending_pc,   pending_pc_d;
    logic [15:0] buf_instr,    buf_instr_d;
    logic [15:0] buf_pc_plus2, buf_pc_plus2_d;
    logic [15:0] pc_inc;
    logic [15:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & 16'hFFFE;
    assign state_q      = fetch_state_t'(state_bits);

    cla_16bit u_pc_inc (
        .a   (fetch_pc),
        .b   (PC_STEP),
        .cin (1'b0),
        .sum (pc_inc)
    );

    // State register
    dff #(.WIDTH(2),  .RST_VAL(FETCH))    u_state_reg   (.clk(clk), .rst(rst), .d(state_d),        .q(state_bits));
    dff #(.WIDTH(16), .RST_VAL(RESET_PC)) u_fetch_pc    (.clk(clk), .rst(rst), .d(fetch_pc_d),     .q(fetch_pc));
    dff #(.WIDTH(16), .RST_VAL('0))       u_pending_pc  (.clk(clk), .rst(rst), .d(pending_pc_d),   .q(pending_pc));
    dff #(.WIDTH(16), .RST_VAL('0))       u_buf_instr   (.clk(clk), .rst(rst), .d(buf_instr_d),    .q(buf_instr));
    dff #(.WIDTH(16), .RST_VAL('0))       u_buf_pc_plus (.clk(clk), .rst(rst), .d(buf_pc_plus2_d), .q(buf_pc_plus2));

    // Next-state and datapath register updates
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc;
        pending_pc_d   = pending_pc;
        buf_instr_d    = buf_instr;
        buf_pc_plus2_d = buf_pc_plus2;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        fetch_pc_d = redirect_tgt;
                    end else begin
                        pending_pc_d = redirect_tgt;
                        state_d      = DROP;
                    end
                end else if (imem.imem_ready) begin
                    fetch_pc_d = pc_inc;
                    if (stall) begin
                        buf_instr_d    = imem.imem_data;
                        buf_pc_plus2_d = pc_inc;
                        state_d        = FULL;
                    end else if (is_hlt(imem.imem_data)) begin
                        state_d = HALT;
                    end
                end
            end

            FULL: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = FETCH;
                end else if (!stall) begin
                    state_d = is_hlt(buf_instr) ? HALT : FETCH;
                end
            end

            DROP: begin
                // The old request must complete before the stored target can be issued.
                if (imem.imem_ready) begin
                    fetch_pc_d = redirect ? redirect_tgt : pending_pc;
                    state_d    = FETCH;
                end else if (redirect) begin
                    pending_pc_d = redirect_tgt;
                end
            end

            HALT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    // Outputs to memory and decode
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = fetch_pc;
        f_valid        = 1'b0;
        f_instruction  = NOP_INSTR;
        f_pc_plus2     = '0;
        halted         = 1'b0;

        if (!rst) begin
            unique case (state_q)
                FETCH: begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_ready && !redirect) begin
                        f_valid       = 1'b1;
                        f_instruction = imem.imem_data;
                        f_pc_plus2    = pc_inc;
                    end
                end
                FULL: begin
                    if (!redirect) begin
                        f_valid       = 1'b1;
                        f_instruction = buf_instr;
                        f_pc_plus2    = buf_pc_plus2;
                    end
                end
                DROP:    imem.imem_req = 1'b1;
                HALT:    halted        = 1'b1;
                default: imem.imem_req = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboarded decode transfers plus cycle-level output checks.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [15:0] redirect_pc;
    logic        f_valid, halted;
    logic [15:0] f_instruction, f_pc_plus2;

    logic        rst2, stall2, redirect2;
    logic [15:0] redirect_pc2;
    logic        f_valid2, halted2;
    logic [15:0] f_instruction2, f_pc_plus22;

    logic [15:0] mem [0:65535];
    xfer_t       sb [$];
    int          total = 0;
    int          bad   = 0;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    assign bus.imem_data  = mem[bus.imem_addr];
    assign bus2.imem_data = mem[bus2.imem_addr];

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem          (bus),
        .f_valid       (f_valid),
        .f_instruction (f_instruction),
        .f_pc_plus2    (f_pc_plus2),
        .halted        (halted)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk           (clk),
        .rst           (rst2),
        .stall         (stall2),
        .redirect      (redirect2),
        .redirect_pc   (redirect_pc2),
        .imem          (bus2),
        .f_valid       (f_valid2),
        .f_instruction (f_instruction2),
        .f_pc_plus2    (f_pc_plus22),
        .halted        (halted2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pc2);
        sb.push_back('{instr: instr, pc2: pc2});
    endtask

    // One cycle: drive at the falling edge, settle, then retire any transfer to decode.
    task automatic step(input logic r, input logic rdy, input logic stl,
                        input logic rd, input logic [15:0] rpc);
        xfer_t e;
        @(negedge clk);
        rst            = r;
        bus.imem_ready = rdy;
        stall          = stl;
        redirect       = rd;
        redirect_pc    = rpc;
        #1;
        if (f_valid && !stall) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_unexpected observed=%h expected=none", f_instruction);
            end else begin
                e = sb.pop_front();
                chk("xfer_instr", f_instruction, e.instr);
                chk("xfer_pc2",   f_pc_plus2,    e.pc2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0000] = 16'h1234;
        mem[16'h0002] = 16'h2567;
        mem[16'h0004] = 16'h3ABC;
        mem[16'h0006] = 16'hF000;
        mem[16'h0010] = 16'hF000;
        mem[16'h0020] = 16'h5222;
        mem[16'h0022] = 16'h6333;
        mem[16'h0030] = 16'h7444;
        mem[16'h0040] = 16'h4111;
        mem[16'h0042] = 16'hF000;
        mem[16'hFFFE] = 16'h8555;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; bus.imem_ready = 1'b1;
        rst2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; bus2.imem_ready = 1'b1;

        step(1, 1, 0, 0, 16'h0000);
        chk("rst_req",   bus.imem_req, 1'b0);
        chk("rst_valid", f_valid, 1'b0);
        chk("rst_halt",  halted, 1'b0);
        chk("rst_instr", f_instruction, NOP_INSTR);

        push(16'h1234, 16'h0002);
        step(0, 1, 0, 0, 16'h0000);
        chk("first_req",  bus.imem_req, 1'b1);
        chk("first_addr", bus.imem_addr, 16'h0000);
        chk("first_valid", f_valid, 1'b1);

        step(0, 0, 0, 0, 16'h0000);
        chk("lat1_addr", bus.imem_addr, 16'h0002);
        chk("lat1_valid", f_valid, 1'b0);
        step(0, 0, 0, 0, 16'h0000);
        chk("lat2_addr", bus.imem_addr, 16'h0002);
        chk("lat2_valid", f_valid, 1'b0);
        push(16'h2567, 16'h0004);
        step(0, 1, 0, 0, 16'h0000);
        chk("lat3_addr", bus.imem_addr, 16'h0002);
        chk("lat3_valid", f_valid, 1'b1);

        step(0, 1, 1, 0, 16'h0000);
        chk("stall_addr", bus.imem_addr, 16'h0004);
        chk("stall_valid", f_valid, 1'b1);
        step(0, 1, 1, 0, 16'h0000);
        chk("full_req",   bus.imem_req, 1'b0);
        chk("full_valid", f_valid, 1'b1);
        chk("full_instr", f_instruction, 16'h3ABC);
        push(16'h3ABC, 16'h0006);
        step(0, 1, 0, 0, 16'h0000);
        chk("release_req", bus.imem_req, 1'b0);
        chk("release_pc2", f_pc_plus2, 16'h0006);

        step(0, 0, 0, 1, 16'h0011);
        chk("rd_a_addr",  bus.imem_addr, 16'h0006);
        chk("rd_a_valid", f_valid, 1'b0);
        step(0, 1, 0, 0, 16'h0000);
        chk("drop_a_req",   bus.imem_req, 1'b1);
        chk("drop_a_valid", f_valid, 1'b0);

        step(0, 0, 0, 1, 16'h0040);
        chk("rd_b_addr",  bus.imem_addr, 16'h0010);
        chk("rd_b_valid", f_valid, 1'b0);
        step(0, 0, 0, 0, 16'h0000);
        chk("drop_b1_addr", bus.imem_addr, 16'h0010);
        chk("drop_b1_req",  bus.imem_req, 1'b1);
        step(0, 1, 0, 0, 16'h0000);
        chk("drop_b2_addr",  bus.imem_addr, 16'h0010);
        chk("drop_b2_valid", f_valid, 1'b0);
        push(16'h4111, 16'h0042);
        step(0, 1, 0, 0, 16'h0000);
        chk("tgt_addr", bus.imem_addr, 16'h0040);

        step(0, 1, 0, 1, 16'h0006);
        chk("rd_ready_valid", f_valid, 1'b0);
        push(16'hF000, 16'h0008);
        step(0, 1, 0, 0, 16'h0000);
        chk("hlt_addr", bus.imem_addr, 16'h0006);
        step(0, 1, 0, 0, 16'h0000);
        chk("halt_flag",  halted, 1'b1);
        chk("halt_req",   bus.imem_req, 1'b0);
        chk("halt_valid", f_valid, 1'b0);
        step(0, 1, 0, 0, 16'h0000);
        chk("halt_hold", halted, 1'b1);
        step(0, 1, 0, 1, 16'h0020);
        chk("halt_rd_flag", halted, 1'b1);
        step(0, 0, 0, 0, 16'h0000);
        chk("unhalt_flag", halted, 1'b0);
        chk("unhalt_req",  bus.imem_req, 1'b1);
        chk("unhalt_addr", bus.imem_addr, 16'h0020);
        push(16'h5222, 16'h0022);
        step(0, 1, 0, 0, 16'h0000);

        step(0, 1, 1, 0, 16'h0000);
        chk("fullrd_cap_valid", f_valid, 1'b1);
        step(0, 1, 1, 1, 16'h0030);
        chk("fullrd_valid", f_valid, 1'b0);
        chk("fullrd_req",   bus.imem_req, 1'b0);
        push(16'h7444, 16'h0032);
        step(0, 1, 0, 0, 16'h0000);
        chk("fullrd_addr", bus.imem_addr, 16'h0030);

        step(0, 0, 0, 0, 16'h0000);
        chk("mid_addr", bus.imem_addr, 16'h0032);
        step(1, 0, 0, 0, 16'h0000);
        chk("mid_rst_req", bus.imem_req, 1'b0);
        push(16'h1234, 16'h0002);
        step(0, 1, 0, 0, 16'h0000);
        chk("mid_rst_addr", bus.imem_addr, 16'h0000);

        chk("sb_drain", 16'(sb.size()), 16'h0000);

        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("wrap_addr",  bus2.imem_addr, 16'hFFFE);
        chk("wrap_valid", f_valid2, 1'b1);
        chk("wrap_instr", f_instruction2, 16'h8555);
        chk("wrap_pc2",   f_pc_plus22, 16'h0000);
        @(negedge clk);
        #1;
        chk("wrap_next_addr", bus2.imem_addr, 16'h0000);
        chk("wrap_next_pc2",  f_pc_plus22, 16'h0002);
        chk("wrap_halt",      halted2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
